// File: rtl/register_file_if.sv
// Bus bundle for the register file: two combinational read ports, one write port
// and the committed-write debug counter.
interface register_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [7:0]        wr_count;

  // Handshake: there is no ready. wr_en acts as a valid qualifier, and the write
  // commits on every rising clk where wr_en=1 and wr_addr!=0. Reads have no
  // qualifier: rd_dataN follows rd_addrN combinationally.
  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
    input  rd_data1, rd_data2, wr_count
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
    output rd_data1, rd_data2, wr_count
  );
endinterface

// File: rtl/register_file.sv
// MIPS 32 x 32 general-purpose register file: async reads with same-cycle
// write-to-read bypass, one write port, $zero hardwired, saturating write counter.
module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  register_file_if.slave  rf
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_commit;

  assign wr_commit = rf.wr_en && (rf.wr_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      rf.wr_count <= '0;
    end else if (wr_commit) begin
      regs[rf.wr_addr] <= rf.wr_data;
      if (rf.wr_count != 8'hFF) rf.wr_count <= rf.wr_count + 8'd1;
    end
  end

  // Reads are forced to 0 while in reset so no pending bypass leaks through.
  always_comb begin
    rf.rd_data1 = '0;
    if (rst_n && (rf.rd_addr1 != '0)) begin
      if (wr_commit && (rf.wr_addr == rf.rd_addr1)) rf.rd_data1 = rf.wr_data;
      else                                          rf.rd_data1 = regs[rf.rd_addr1];
    end
  end

  always_comb begin
    rf.rd_data2 = '0;
    if (rst_n && (rf.rd_addr2 != '0)) begin
      if (wr_commit && (rf.wr_addr == rf.rd_addr2)) rf.rd_data2 = rf.wr_data;
      else                                          rf.rd_data2 = regs[rf.rd_addr2];
    end
  end
endmodule
